// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with brightness PWM and frame-aligned
// value update. Define SSD_LZ_BLANK_EN to enable leading-zero suppression.
module ssd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BRIGHT_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [15:0]         value_in,
  input  logic [3:0]          dp_in,
  input  logic [3:0]          digit_en,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [3:0]          AN,
  output logic [3:0]          digit_val,
  output logic                dp_out,
  output logic                blank,
  output logic                frame_done
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW:0] StepLen = (CntW+1)'(REFRESH_DIV / 8);

  typedef enum logic [1:0] {StDead, StOn, StOff} state_e;

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [CntW:0] on_len_q, on_len_d;
  logic [15:0]   active_q, active_d, shadow_q, shadow_d;
  logic [3:0]    active_dp_q, active_dp_d, shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_d, digit_val_d;
  logic          dp_out_d, blank_d, frame_done_d;
  logic          wrap, frame_edge;
  logic [3:0]    en_eff;

`ifdef SSD_LZ_BLANK_EN
  logic [3:0] lz;
  // A digit is suppressed only when it and every higher digit are blank zeros.
  always_comb begin
    lz[3] = (active_q[15:12] == 4'h0) && !active_dp_q[3];
    lz[2] = lz[3] && (active_q[11:8] == 4'h0) && !active_dp_q[2];
    lz[1] = lz[2] && (active_q[7:4] == 4'h0) && !active_dp_q[1];
    lz[0] = 1'b0;
    en_eff = digit_en & ~lz;
  end
`else
  always_comb en_eff = digit_en;
`endif

  always_comb begin
    wrap       = (cnt_q == CntW'(REFRESH_DIV - 1));
    frame_edge = wrap && (idx_q == 2'd3);
    cnt_d      = wrap ? '0 : cnt_q + CntW'(1);
    idx_d      = wrap ? idx_q + 2'd1 : idx_q;
    on_len_d   = on_len_q;
    state_d    = state_q;
    unique case (state_q)
      StDead: begin
        on_len_d = ((CntW+1)'(brightness) + (CntW+1)'(1)) * StepLen;
        state_d  = en_eff[idx_q] ? StOn : StOff;
      end
      StOn: begin
        if (wrap) state_d = StDead;
        else if ({1'b0, cnt_q} == on_len_q - (CntW+1)'(1)) state_d = StOff;
      end
      StOff: if (wrap) state_d = StDead;
      default: state_d = StDead;
    endcase
  end

  // Shadow/active handshake; a load on the frame edge bypasses the shadow.
  always_comb begin
    shadow_d    = load ? value_in : shadow_q;
    shadow_dp_d = load ? dp_in : shadow_dp_q;
    pending_d   = frame_edge ? 1'b0 : (load | pending_q);
    active_d    = active_q;
    active_dp_d = active_dp_q;
    if (frame_edge) begin
      if (load) begin
        active_d    = value_in;
        active_dp_d = dp_in;
      end else if (pending_q) begin
        active_d    = shadow_q;
        active_dp_d = shadow_dp_q;
      end
    end
  end

  // Outputs are derived from next-state so the registered pins track the state register.
  always_comb begin
    an_d         = (state_d == StOn) ? ~(4'b0001 << idx_d) : 4'hF;
    blank_d      = (state_d != StOn);
    digit_val_d  = active_d[4*idx_d +: 4];
    dp_out_d     = active_dp_d[idx_d];
    frame_done_d = frame_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDead;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      on_len_q    <= '0;
      active_q    <= 16'h0;
      active_dp_q <= 4'h0;
      shadow_q    <= 16'h0;
      shadow_dp_q <= 4'h0;
      pending_q   <= 1'b0;
      AN          <= 4'hF;
      digit_val   <= 4'h0;
      dp_out      <= 1'b0;
      blank       <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      on_len_q    <= on_len_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      AN          <= an_d;
      digit_val   <= digit_val_d;
      dp_out      <= dp_out_d;
      blank       <= blank_d;
      frame_done  <= frame_done_d;
    end
  end

endmodule
